// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction register with valid/ready handoff, jump redirect and halt detection.
// Optional macro FETCH_COUNT_EN adds a saturating accepted-instruction counter port.
module instr_fetch_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = '1
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);
  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  logic [1:0] state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic valid_q, valid_d, halted_q, halted_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    halted_d = halted_q;
    case (state_q)
      PRIME: state_d = RUN;
      RUN:
        if (jump_en) begin
          pc_d = jump_target;
          valid_d = 1'b0;
        end else if (!valid_q || ir_ready) begin
          ir_d = mem_data;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
          if (mem_data == HALT_OPCODE) begin
            state_d = HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      HALTED:
        if (jump_en) begin
          pc_d = jump_target;
          valid_d = 1'b0;
          halted_d = 1'b0;
          state_d = RUN;
        end else if (ir_ready) begin
          valid_d = 1'b0;
        end
      default: state_d = PRIME;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRIME;
      pc_q <= RESET_PC;
      ir_q <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      halted_q <= halted_d;
    end
  end
  assign mem_address = pc_q;
  assign ir_out = ir_q;
  assign ir_pc = ir_pc_q;
  assign ir_valid = valid_q;
  assign halted = halted_q;
`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = (valid_q && ir_ready && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign fetch_count = cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand sequences for async reset and fetch counting.
module tb_instr_fetch_unit;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] mem_address;
  logic [7:0] mem_data;
  logic jump_en;
  logic [3:0] jump_target;
  logic ir_ready;
  logic [7:0] ir_out;
  logic [3:0] ir_pc;
  logic ir_valid;
  logic halted;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [16];

  instr_fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .mem_address(mem_address), .mem_data(mem_data),
    .jump_en(jump_en), .jump_target(jump_target), .ir_ready(ir_ready),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;
  always @(negedge clock) mem_data <= mem[mem_address];

  typedef struct {
    logic j; logic [3:0] t; logic r;
    logic v; logic [7:0] ir; logic [3:0] ipc; logic [3:0] a; logic h;
  } vec_t;
  vec_t vt [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input int i, input logic v, input logic [7:0] ir, input logic [3:0] ipc,
                         input logic [3:0] a, input logic h);
    chk($sformatf("v%0d ir_valid", i), {31'd0, ir_valid}, {31'd0, v});
    chk($sformatf("v%0d ir_out", i), {24'd0, ir_out}, {24'd0, ir});
    chk($sformatf("v%0d ir_pc", i), {28'd0, ir_pc}, {28'd0, ipc});
    chk($sformatf("v%0d mem_address", i), {28'd0, mem_address}, {28'd0, a});
    chk($sformatf("v%0d halted", i), {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    mem[0] = 8'd1; mem[1] = 8'd15; mem[2] = 8'd5; mem[3] = 8'hFF; mem[15] = 8'd7;
    //              j  t   r   v  ir     ipc a   h
    vt[0]  = '{1'b0, 4'd0, 1'b1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0};
    vt[1]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0};
    vt[2]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    vt[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    vt[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    vt[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    vt[6]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd5, 4'd2, 4'd3, 1'b0};
    vt[7]  = '{1'b1, 4'd0, 1'b1, 1'b0, 8'd5, 4'd2, 4'd0, 1'b0};
    vt[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0};
    vt[9]  = '{1'b1, 4'd2, 1'b0, 1'b0, 8'd1, 4'd0, 4'd2, 1'b0};
    vt[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd5, 4'd2, 4'd3, 1'b0};
    vt[11] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'hFF, 4'd3, 4'd3, 1'b1};
    vt[12] = '{1'b0, 4'd0, 1'b0, 1'b1, 8'hFF, 4'd3, 4'd3, 1'b1};
    vt[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 8'hFF, 4'd3, 4'd3, 1'b1};
    vt[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 8'hFF, 4'd3, 4'd3, 1'b1};
    vt[15] = '{1'b1, 4'd0, 1'b1, 1'b0, 8'hFF, 4'd3, 4'd0, 1'b0};
    vt[16] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0};
    vt[17] = '{1'b1, 4'd15, 1'b1, 1'b0, 8'd1, 4'd0, 4'd15, 1'b0};
    vt[18] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd7, 4'd15, 4'd0, 1'b0};
    vt[19] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0};
    vt[20] = '{1'b1, 4'd3, 1'b1, 1'b0, 8'd1, 4'd0, 4'd3, 1'b0};
    vt[21] = '{1'b1, 4'd0, 1'b1, 1'b0, 8'd1, 4'd0, 4'd0, 1'b0};
    vt[22] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0};
    vt[23] = '{1'b0, 4'd0, 1'b1, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    vt[24] = '{1'b0, 4'd0, 1'b0, 1'b1, 8'd15, 4'd1, 4'd2, 1'b0};
    reset_n = 1'b0; jump_en = 1'b0; jump_target = 4'd0; ir_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_all(-1, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
`ifdef FETCH_COUNT_EN
    chk("count reset", {16'd0, fetch_count}, 32'd0);
`endif
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      jump_en = vt[i].j; jump_target = vt[i].t; ir_ready = vt[i].r;
      @(posedge clock);
      #1;
      chk_all(i, vt[i].v, vt[i].ir, vt[i].ipc, vt[i].a, vt[i].h);
    end
    // mid-stall async reset, checked before any further clock edge
    jump_en = 1'b0; ir_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk_all(100, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
`ifdef FETCH_COUNT_EN
    chk("count async reset", {16'd0, fetch_count}, 32'd0);
`endif
    @(posedge clock);
    #1 reset_n = 1'b1; ir_ready = 1'b1;
    @(posedge clock);
    #1 chk_all(101, 1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
    @(posedge clock);
    #1 chk_all(102, 1'b1, 8'd1, 4'd0, 4'd1, 1'b0);
    repeat (3) @(posedge clock);
    #1 chk_all(103, 1'b1, 8'hFF, 4'd3, 4'd3, 1'b1);
`ifdef FETCH_COUNT_EN
    chk("count three accepts", {16'd0, fetch_count}, 32'd3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
